// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multicycle MIPS control unit.
// master = control unit side, slave = datapath/memory side.
interface multicycle_control_if;
    logic       MemReady;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic [3:0] ALUOperation;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ZeroExt;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       RegWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic [1:0] PCSource;
    logic [3:0] State;
    logic       Illegal;

    modport master (
        input  MemReady, Opcode, Funct,
        output ALUOperation, ALUSrcA, ALUSrcB, ZeroExt, IorD, MemRead, MemWrite,
               IRWrite, PCWrite, PCWriteCond, RegWrite, RegDst, MemtoReg,
               PCSource, State, Illegal
    );

    modport slave (
        output MemReady, Opcode, Funct,
        input  ALUOperation, ALUSrcA, ALUSrcB, ZeroExt, IorD, MemRead, MemWrite,
               IRWrite, PCWrite, PCWriteCond, RegWrite, RegDst, MemtoReg,
               PCSource, State, Illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore FSM control unit for the multicycle MIPS datapath.
// Optional feature: define ILLEGAL_OP_TRAP_EN to trap illegal instructions in HALT.
module multicycle_control #(
    parameter int STATE_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = STATE_W'(0),
        S_DECODE   = STATE_W'(1),
        S_EXEC_R   = STATE_W'(2),
        S_RWB      = STATE_W'(3),
        S_MEMADDR  = STATE_W'(4),
        S_MEMREAD  = STATE_W'(5),
        S_MEMWB    = STATE_W'(6),
        S_MEMWRITE = STATE_W'(7),
        S_EXEC_I   = STATE_W'(8),
        S_IWB      = STATE_W'(9),
        S_BRANCH   = STATE_W'(10),
        S_JUMP     = STATE_W'(11),
        S_HALT     = STATE_W'(12)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_NOR = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b0110;

    // Returns {valid, alu_op}; valid=0 flags an unsupported R-type function.
    function automatic logic [4:0] funct_decode(input logic [5:0] funct);
        logic [4:0] res;
        case (funct)
            6'h20:   res = {1'b1, ALU_ADD};
            6'h22:   res = {1'b1, ALU_SUB};
            6'h24:   res = {1'b1, ALU_AND};
            6'h25:   res = {1'b1, ALU_OR};
            6'h27:   res = {1'b1, ALU_NOR};
            6'h00:   res = {1'b1, ALU_SLL};
            6'h02:   res = {1'b1, ALU_SRL};
            default: res = {1'b0, ALU_AND};
        endcase
        return res;
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [4:0] fdec_s;

    assign fdec_s = funct_decode(bus.Funct);

    // State register; reset lands in FETCH immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_next_s     = S_FETCH;
        bus.ALUOperation = ALU_AND;
        bus.ALUSrcA      = 1'b0;
        bus.ALUSrcB      = 2'b00;
        bus.ZeroExt      = 1'b0;
        bus.IorD         = 1'b0;
        bus.MemRead      = 1'b0;
        bus.MemWrite     = 1'b0;
        bus.IRWrite      = 1'b0;
        bus.PCWrite      = 1'b0;
        bus.PCWriteCond  = 1'b0;
        bus.RegWrite     = 1'b0;
        bus.RegDst       = 1'b0;
        bus.MemtoReg     = 1'b0;
        bus.PCSource     = 2'b00;
        bus.Illegal      = 1'b0;
        bus.State        = 4'(state_r);

        case (state_r)
            S_FETCH: begin
                bus.MemRead      = 1'b1;
                bus.ALUSrcB      = 2'b01;
                bus.ALUOperation = ALU_ADD;
                bus.IRWrite      = bus.MemReady;
                bus.PCWrite      = bus.MemReady;
                if (bus.MemReady) begin
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_FETCH;
                end
            end
            S_DECODE: begin
                bus.ALUSrcB      = 2'b11;
                bus.ALUOperation = ALU_ADD;
                case (bus.Opcode)
                    OP_RTYPE:               state_next_s = S_EXEC_R;
                    OP_LW, OP_SW:           state_next_s = S_MEMADDR;
                    OP_ADDI, OP_ANDI, OP_ORI: state_next_s = S_EXEC_I;
                    OP_BEQ:                 state_next_s = S_BRANCH;
                    OP_J:                   state_next_s = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:                state_next_s = S_HALT;
`else
                    default:                state_next_s = S_FETCH;
`endif
                endcase
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                if (fdec_s[4]) begin
                    bus.ALUOperation = fdec_s[3:0];
                    state_next_s     = S_RWB;
                end else begin
                    bus.ALUOperation = ALU_AND;
`ifdef ILLEGAL_OP_TRAP_EN
                    state_next_s     = S_HALT;
`else
                    state_next_s     = S_FETCH;
`endif
                end
            end
            S_RWB: begin
                bus.RegDst   = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_MEMADDR: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUSrcB      = 2'b10;
                bus.ALUOperation = ALU_ADD;
                if (bus.Opcode == OP_LW) begin
                    state_next_s = S_MEMREAD;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
                if (bus.MemReady) begin
                    state_next_s = S_MEMWB;
                end else begin
                    state_next_s = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_MEMWRITE: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
                if (bus.MemReady) begin
                    state_next_s = S_FETCH;
                end else begin
                    state_next_s = S_MEMWRITE;
                end
            end
            S_EXEC_I: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUSrcB  = 2'b10;
                state_next_s = S_IWB;
                case (bus.Opcode)
                    OP_ANDI: begin
                        bus.ALUOperation = ALU_AND;
                        bus.ZeroExt      = 1'b1;
                    end
                    OP_ORI: begin
                        bus.ALUOperation = ALU_OR;
                        bus.ZeroExt      = 1'b1;
                    end
                    default: bus.ALUOperation = ALU_ADD;
                endcase
            end
            S_IWB: begin
                // ZeroExt follows the opcode still held in IR.
                bus.RegWrite = 1'b1;
                bus.ZeroExt  = (bus.Opcode == OP_ANDI) || (bus.Opcode == OP_ORI);
            end
            S_BRANCH: begin
                bus.ALUSrcA      = 1'b1;
                bus.ALUOperation = ALU_SUB;
                bus.PCWriteCond  = 1'b1;
                bus.PCSource     = 2'b01;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_HALT: begin
                bus.Illegal  = 1'b1;
                state_next_s = S_HALT;
            end
`endif
            default: state_next_s = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control (honours ILLEGAL_OP_TRAP_EN).
module tb_multicycle_control;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    multicycle_control_if bus();

    multicycle_control #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and check the state reached.
    task automatic step(input logic [3:0] exp_state);
        @(negedge clk);
        check_val("state", 32'(bus.State), 32'(exp_state));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_val("rst_state", 32'(bus.State), 32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus.MemReady = 1'b1;
        bus.Opcode   = 6'h00;
        bus.Funct    = 6'h22;
        #3;
        check_val("rst_state", 32'(bus.State), 32'd0);
        check_val("rst_memread", 32'(bus.MemRead), 32'd1);
        check_val("rst_aluop", 32'(bus.ALUOperation), 32'd3);
        check_val("rst_irwrite", 32'(bus.IRWrite), 32'd1);
        check_val("rst_memwrite", 32'(bus.MemWrite), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // R-type sub: 0,1,2,3,0
        check_val("fetch_alusrcb", 32'(bus.ALUSrcB), 32'd1);
        check_val("fetch_pcwrite", 32'(bus.PCWrite), 32'd1);
        step(4'd1);
        check_val("dec_alusrcb", 32'(bus.ALUSrcB), 32'd3);
        check_val("dec_aluop", 32'(bus.ALUOperation), 32'd3);
        step(4'd2);
        check_val("sub_aluop", 32'(bus.ALUOperation), 32'd4);
        check_val("sub_alusrca", 32'(bus.ALUSrcA), 32'd1);
        check_val("sub_regwrite", 32'(bus.RegWrite), 32'd0);
        step(4'd3);
        check_val("rwb_regwrite", 32'(bus.RegWrite), 32'd1);
        check_val("rwb_regdst", 32'(bus.RegDst), 32'd1);
        check_val("rwb_memtoreg", 32'(bus.MemtoReg), 32'd0);
        step(4'd0);

        // Fetch stall, then lw with two wait cycles: 0,0,1,4,5,5,5,6,0
        bus.MemReady = 1'b0;
        #1;
        check_val("stall_irwrite", 32'(bus.IRWrite), 32'd0);
        check_val("stall_pcwrite", 32'(bus.PCWrite), 32'd0);
        step(4'd0);
        check_val("stall_memread", 32'(bus.MemRead), 32'd1);
        bus.MemReady = 1'b1;
        bus.Opcode   = 6'h23;
        step(4'd1);
        step(4'd4);
        check_val("maddr_alusrcb", 32'(bus.ALUSrcB), 32'd2);
        check_val("maddr_aluop", 32'(bus.ALUOperation), 32'd3);
        bus.MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(4'd5);
            check_val("lw_memread", 32'(bus.MemRead), 32'd1);
            check_val("lw_iord", 32'(bus.IorD), 32'd1);
        end
        bus.MemReady = 1'b1;
        step(4'd6);
        check_val("memwb_regwrite", 32'(bus.RegWrite), 32'd1);
        check_val("memwb_memtoreg", 32'(bus.MemtoReg), 32'd1);
        check_val("memwb_regdst", 32'(bus.RegDst), 32'd0);
        step(4'd0);

        // sw: 0,1,4,7,0
        bus.Opcode = 6'h2B;
        step(4'd1);
        step(4'd4);
        step(4'd7);
        check_val("sw_memwrite", 32'(bus.MemWrite), 32'd1);
        check_val("sw_iord", 32'(bus.IorD), 32'd1);
        check_val("sw_memread", 32'(bus.MemRead), 32'd0);
        step(4'd0);

        // ori: 0,1,8,9,0
        bus.Opcode = 6'h0D;
        step(4'd1);
        step(4'd8);
        check_val("ori_aluop", 32'(bus.ALUOperation), 32'd1);
        check_val("ori_zeroext", 32'(bus.ZeroExt), 32'd1);
        check_val("ori_alusrcb", 32'(bus.ALUSrcB), 32'd2);
        step(4'd9);
        check_val("iwb_regwrite", 32'(bus.RegWrite), 32'd1);
        check_val("iwb_regdst", 32'(bus.RegDst), 32'd0);
        check_val("iwb_zeroext", 32'(bus.ZeroExt), 32'd1);
        step(4'd0);

        // andi: AND with zero extension
        bus.Opcode = 6'h0C;
        step(4'd1);
        step(4'd8);
        check_val("andi_aluop", 32'(bus.ALUOperation), 32'd0);
        check_val("andi_zeroext", 32'(bus.ZeroExt), 32'd1);
        step(4'd9);
        step(4'd0);

        // beq: 0,1,10,0
        bus.Opcode = 6'h04;
        step(4'd1);
        step(4'd10);
        check_val("beq_pcwritecond", 32'(bus.PCWriteCond), 32'd1);
        check_val("beq_aluop", 32'(bus.ALUOperation), 32'd4);
        check_val("beq_pcsource", 32'(bus.PCSource), 32'd1);
        check_val("beq_pcwrite", 32'(bus.PCWrite), 32'd0);
        step(4'd0);

        // j: 0,1,11,0
        bus.Opcode = 6'h02;
        step(4'd1);
        step(4'd11);
        check_val("j_pcwrite", 32'(bus.PCWrite), 32'd1);
        check_val("j_pcsource", 32'(bus.PCSource), 32'd2);
        step(4'd0);

        // Asynchronous reset while waiting in MEMWRITE
        bus.Opcode = 6'h2B;
        step(4'd1);
        step(4'd4);
        bus.MemReady = 1'b0;
        step(4'd7);
        check_val("mw_hold", 32'(bus.MemWrite), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("arst_state", 32'(bus.State), 32'd0);
        check_val("arst_memwrite", 32'(bus.MemWrite), 32'd0);
        check_val("arst_memread", 32'(bus.MemRead), 32'd1);
        @(negedge clk);
        reset        = 1'b1;
        bus.MemReady = 1'b1;
        check_val("rel_memread", 32'(bus.MemRead), 32'd1);
        check_val("rel_aluop", 32'(bus.ALUOperation), 32'd3);
        step(4'd1);
        step(4'd4);
        step(4'd7);
        step(4'd0);

        // Illegal opcode
        bus.Opcode = 6'h3F;
        step(4'd1);
`ifdef ILLEGAL_OP_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            step(4'd12);
            check_val("halt_illegal", 32'(bus.Illegal), 32'd1);
            check_val("halt_strobes", 32'({bus.RegWrite, bus.MemWrite, bus.PCWrite, bus.MemRead}), 32'd0);
        end
        do_reset();
`else
        step(4'd0);
        check_val("nop_illegal", 32'(bus.Illegal), 32'd0);
        check_val("nop_wr", 32'({bus.RegWrite, bus.MemWrite}), 32'd0);
`endif

        // Illegal funct
        bus.Opcode = 6'h00;
        bus.Funct  = 6'h3F;
        step(4'd1);
        step(4'd2);
        check_val("badf_regwrite", 32'(bus.RegWrite), 32'd0);
        check_val("badf_aluop", 32'(bus.ALUOperation), 32'd0);
`ifdef ILLEGAL_OP_TRAP_EN
        step(4'd12);
        check_val("badf_illegal", 32'(bus.Illegal), 32'd1);
        step(4'd12);
        do_reset();
`else
        step(4'd0);
        check_val("badf_nop_illegal", 32'(bus.Illegal), 32'd0);
        step(4'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM control unit for the multicycle MIPS datapath.
- Drives the ALUOperation code consumed by the ALU, plus all datapath mux selects and write strobes.
- Sequences fetch/decode/execute/memory/writeback per instruction, and stalls on memory through a ready handshake.

Parameters:
- STATE_W, 4, state register width (13 states used).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemReady  input  1  memory completes the current read/write this cycle.
- Opcode  input  6  instruction[31:26] from IR.
- Funct  input  6  instruction[5:0] from IR.
- ALUOperation  output  4  AND=0000 OR=0001 NOR=0010 ADD=0011 SUB=0100 SLL=0101 SRL=0110.
- ALUSrcA  output  1  0=PC, 1=regA.
- ALUSrcB  output  2  00=regB, 01=const 4, 10=sign/zero-ext imm, 11=ext imm<<2.
- ZeroExt  output  1  immediate zero-extended (andi/ori).
- IorD  output  1  0=PC address, 1=ALUOut address.
- MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite  output  1 each  strobes.
- RegDst  output  1  0=rt, 1=rd.
- MemtoReg  output  1  0=ALUOut, 1=MDR.
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- State  output  4  current state (debug).
- Illegal  output  1  illegal-instruction flag.

Behaviour:
- Asynchronous reset (reset=0) forces State=FETCH immediately; the FSM releases on the first rising clk edge after reset=1.
- Outputs are decoded combinationally from State, plus Funct/Opcode/MemReady where noted. Any output not listed for a state is 0; ALUOperation defaults to 0000.
- FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOperation=ADD, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Stay in FETCH while MemReady=0; otherwise go to DECODE.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOperation=ADD. Next state by Opcode:
  - 0x00 -> EXEC_R.
  - 0x23 or 0x2B -> MEMADDR.
  - 0x08, 0x0C, 0x0D -> EXEC_I.
  - 0x04 -> BRANCH.
  - 0x02 -> JUMP.
  - Any other opcode -> illegal handling.
- EXEC_R(2): ALUSrcA=1, ALUSrcB=00. ALUOperation from Funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x27 NOR, 0x00 SLL, 0x02 SRL.
  - Any other Funct -> illegal handling.
  - Next state RWB.
- RWB(3): RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- MEMADDR(4): ALUSrcA=1, ALUSrcB=10, ADD -> MEMREAD if Opcode=0x23, else MEMWRITE.
- MEMREAD(5): MemRead=1, IorD=1; hold until MemReady=1 -> MEMWB.
- MEMWB(6): RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWRITE(7): MemWrite=1, IorD=1; hold until MemReady=1 -> FETCH.
- EXEC_I(8): ALUSrcA=1, ALUSrcB=10. Opcode selects the operation:
  - 0x08 -> ADD.
  - 0x0C -> AND, ZeroExt=1.
  - 0x0D -> OR, ZeroExt=1.
  - Next state IWB.
- IWB(9): RegDst=0, MemtoReg=0, RegWrite=1, ZeroExt unchanged -> FETCH.
- BRANCH(10): ALUSrcA=1, ALUSrcB=00, SUB, PCWriteCond=1, PCSource=01 -> FETCH.
- JUMP(11): PCWrite=1, PCSource=10 -> FETCH.
- HALT(12): all strobes 0; Illegal=1; no exit except reset.
- Latency with MemReady tied 1, counted from entering FETCH to re-entering FETCH:
  - R-type / imm: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq / j: 3 cycles.
- Each extra MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- MemRead/MemWrite/IorD stay stable for the whole wait.
- Reset mid-instruction aborts immediately; MemWrite/RegWrite drop in the same instant.
- States 13-15 (unreachable) transition to FETCH with all strobes 0.

Optional Feature:
- Macro ILLEGAL_OP_TRAP_EN.
- Defined: an illegal Opcode (in DECODE) or illegal Funct (in EXEC_R) goes to HALT; Illegal=1 until reset.
- Undefined: illegal instructions behave as a NOP, returning to FETCH with no RegWrite/MemWrite/PC write. HALT is never entered and Illegal is tied 0.

Test Plan:
- reset=0 mid-MEMWRITE -> State=0 and MemWrite=0 asynchronously; after release, first cycle shows MemRead=1, ALUOperation=0011.
- MemReady=1, Opcode=0x00, Funct=0x22 -> states 0,1,2,3,0; ALUOperation=0100 in EXEC_R; RegWrite=1 and RegDst=1 for one cycle.
- lw (0x23), MemReady low 2 cycles in MEMREAD -> states 0,1,4,5,5,5,6,0; MemRead and IorD held at 1 throughout.
- ori (0x0D) -> EXEC_I shows ALUOperation=0001, ZeroExt=1, ALUSrcB=10; IWB RegWrite=1 with RegDst=0.
- beq then j -> beq: BRANCH shows PCWriteCond=1, SUB, PCSource=01; j: JUMP shows PCWrite=1, PCSource=10; each takes 3 cycles.
- Opcode=0x3F, and separately Opcode=0x00 with Funct=0x3F:
  - With ILLEGAL_OP_TRAP_EN: State=12, Illegal=1, stuck until reset.
  - Without: return to FETCH, no write strobes, Illegal=0.
